// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - operand stream, control and result bundle for mac_seq
interface mac_seq_if;
   logic               start;
   logic signed [31:0] a_in;
   logic signed [31:0] b_in;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] mac_out;
   logic [15:0]        sel;
   logic               ovf;
   logic               out_ack;

   modport master (
      input  start, a_in, b_in, in_valid, out_ack,
      output in_ready, mac_out, sel, ovf
   );

   modport slave (
      output start, a_in, b_in, in_valid, out_ack,
      input  in_ready, mac_out, sel, ovf
   );
endinterface

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - LEN-pair multiply-accumulate with one-hot state code on sel
module mac_seq #(
   parameter int LEN = 4
) (
   input logic       clk,
   input logic       rst,
   mac_seq_if.master bus
);
   localparam int CNT_W = $clog2(LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_ACCUM = 4'b0010,
      S_DONE  = 4'b0100,
      S_DRAIN = 4'b1000
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   count_q;
   logic signed [31:0] prod_q;
   logic               prod_v_q;
   logic signed [31:0] acc_q;
   logic               ovf_q;
   logic               ready;
   logic               accept;
   logic signed [31:0] sum;
   logic               sum_ovf;

   assign ready   = (state_q == S_ACCUM) && (count_q < CNT_W'(LEN));
   assign accept  = ready && bus.in_valid;
   assign sum     = acc_q + prod_q;
   // Wrap detection: equal-sign addends producing a result of the other sign.
   assign sum_ovf = (acc_q[31] == prod_q[31]) && (sum[31] != acc_q[31]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_ACCUM;
         S_ACCUM: if (accept && (count_q == CNT_W'(LEN - 1))) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  if (bus.out_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         prod_q   <= '0;
         prod_v_q <= 1'b0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prod_v_q <= accept;
         if (accept) begin
            prod_q  <= bus.a_in * bus.b_in;
            count_q <= count_q + 1'b1;
         end
         if (state_q == S_IDLE && bus.start) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else if (prod_v_q) begin
            acc_q <= sum;
            if (sum_ovf) ovf_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready = ready;
   assign bus.mac_out  = acc_q;
   assign bus.sel      = {12'b0, state_q};
   assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed checks of mac_seq with LEN=4
module tb_mac_seq;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   cyc;
   logic [31:0] pa [4];
   logic [31:0] pb [4];

   mac_seq_if bus ();

   mac_seq #(.LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts from IDLE and streams pa/pb; returns edges from the start edge until DONE.
   task automatic run_acc(input bit bubble, output int cycles);
      int idx;
      bit phase;
      bit taken;
      idx = 0;
      phase = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cycles = 1;
      while (bus.sel != 16'h0004 && cycles < 60) begin
         if (idx < 4 && (!bubble || phase)) begin
            bus.in_valid = 1'b1;
            bus.a_in = pa[idx];
            bus.b_in = pb[idx];
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bubble && idx < 4 && bus.sel == 16'h0002)
            check("bubble_ready", {31'b0, bus.in_ready}, 32'd1);
         taken = bus.in_valid && bus.in_ready;
         tick();
         cycles++;
         if (taken) idx++;
         phase = !phase;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic ack;
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.in_valid = 1'b1;
      bus.a_in = 32'd7;
      bus.b_in = 32'd9;
      bus.out_ack = 1'b0;
      tick();
      check("rst_sel", bus.sel, 32'h1);
      check("rst_mac", bus.mac_out, 32'h0);
      check("rst_ovf", {31'b0, bus.ovf}, 32'h0);
      check("rst_ready", {31'b0, bus.in_ready}, 32'h0);
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check("idle_sel", bus.sel, 32'h1);

      pa[0] = 1;  pb[0] = 2;
      pa[1] = 3;  pb[1] = 4;
      pa[2] = -5; pb[2] = 6;
      pa[3] = 7;  pb[3] = -1;
      run_acc(1'b0, cyc);
      check("b2b_latency", cyc, 32'd6);
      check("b2b_sel", bus.sel, 32'h4);
      check("b2b_mac", bus.mac_out, 32'hFFFF_FFE9);
      check("b2b_ovf", {31'b0, bus.ovf}, 32'h0);
      check("done_ready", {31'b0, bus.in_ready}, 32'h0);
      bus.start = 1'b1;
      bus.in_valid = 1'b1;
      repeat (3) tick();
      check("hold_sel", bus.sel, 32'h4);
      check("hold_mac", bus.mac_out, 32'hFFFF_FFE9);
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      ack();
      check("ack_sel", bus.sel, 32'h1);
      check("ack_mac", bus.mac_out, 32'hFFFF_FFE9);
      tick();
      check("idle_hold_mac", bus.mac_out, 32'hFFFF_FFE9);

      run_acc(1'b1, cyc);
      check("bub_latency", cyc, 32'd10);
      check("bub_mac", bus.mac_out, 32'hFFFF_FFE9);
      bus.start = 1'b1;
      bus.out_ack = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.out_ack = 1'b0;
      check("coll_sel", bus.sel, 32'h1);
      tick();
      check("coll_no_accum", bus.sel, 32'h1);

      pa[0] = 65536; pb[0] = 32768;
      pa[1] = 65536; pb[1] = 32768;
      pa[2] = 65536; pb[2] = 32768;
      pa[3] = 0;     pb[3] = 0;
      run_acc(1'b0, cyc);
      check("ovf_mac", bus.mac_out, 32'h8000_0000);
      check("ovf_flag", {31'b0, bus.ovf}, 32'h1);
      ack();
      check("ovf_idle_flag", {31'b0, bus.ovf}, 32'h1);

      bus.start = 1'b1;
      tick();
      check("restart_sel", bus.sel, 32'h2);
      check("restart_ovf", {31'b0, bus.ovf}, 32'h0);
      check("restart_mac", bus.mac_out, 32'h0);
      tick();
      check("accum_start_sel", bus.sel, 32'h2);
      check("accum_start_ready", {31'b0, bus.in_ready}, 32'h1);
      bus.in_valid = 1'b1;
      bus.a_in = 2;
      bus.b_in = 3;
      repeat (4) tick();
      check("drain_sel", bus.sel, 32'h8);
      check("drain_ready", {31'b0, bus.in_ready}, 32'h0);
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      check("accum_start_done", bus.sel, 32'h4);
      check("accum_start_mac", bus.mac_out, 32'd24);
      ack();

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.a_in = 5;
      bus.b_in = 5;
      repeat (2) tick();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_sel", bus.sel, 32'h1);
      check("midrst_mac", bus.mac_out, 32'h0);
      check("midrst_ready", {31'b0, bus.in_ready}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         pa[i] = 1;
         pb[i] = 1;
      end
      run_acc(1'b0, cyc);
      check("post_rst_latency", cyc, 32'd6);
      check("post_rst_mac", bus.mac_out, 32'd4);
      check("post_rst_ovf", {31'b0, bus.ovf}, 32'h0);
      ack();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
